// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: drives register file selects, forwards EX/MEM/WB results into the
// operands, inserts a bubble on load-use hazards, and holds the result in a valid/ready ID/EX slot.
module operand_fetch_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rn,
  input  logic [REG_AW-1:0] in_rm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_rn,
  input  logic              in_use_rm,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  output logic [REG_AW-1:0] rf_sel_a,
  output logic [REG_AW-1:0] rf_sel_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr_en,
  output logic              out_is_load,
  output logic [15:0]       stall_cnt
);

  logic              valid_q, valid_d;
  logic              bubble_q, bubble_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wr_en_q, wr_en_d, is_load_q, is_load_d;
  logic [15:0]       stall_q, stall_d;

  logic              hazard, can_load, accept;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  assign rf_sel_a = in_rn;
  assign rf_sel_b = in_rm;

  // A load in EX has no data yet, so it is never a forwarding source.
  always_comb begin
    fwd_a = rf_data_a;
    if (!in_use_rn)                                      fwd_a = '0;
    else if (ex_wr_en && ex_rd == in_rn && !ex_is_load)  fwd_a = ex_result;
    else if (mem_wr_en && mem_rd == in_rn)               fwd_a = mem_result;
    else if (wb_wr_en && wb_rd == in_rn)                 fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = rf_data_b;
    if (!in_use_rm)                                      fwd_b = '0;
    else if (ex_wr_en && ex_rd == in_rm && !ex_is_load)  fwd_b = ex_result;
    else if (mem_wr_en && mem_rd == in_rm)               fwd_b = mem_result;
    else if (wb_wr_en && wb_rd == in_rm)                 fwd_b = wb_data;
  end

  assign hazard   = in_valid && ex_wr_en && ex_is_load &&
                    ((in_use_rn && ex_rd == in_rn) || (in_use_rm && ex_rd == in_rm));
  assign can_load = !valid_q || out_ready;
  assign in_ready = can_load && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Bubble state behaves like empty; the flag only records that a bubble was issued.
  always_comb begin
    valid_d   = valid_q;
    bubble_d  = bubble_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rd_d      = rd_q;
    wr_en_d   = wr_en_q;
    is_load_d = is_load_q;
    stall_d   = stall_q;
    if (reset) begin
      valid_d   = 1'b0;
      bubble_d  = 1'b0;
      op_a_d    = '0;
      op_b_d    = '0;
      rd_d      = '0;
      wr_en_d   = 1'b0;
      is_load_d = 1'b0;
      stall_d   = '0;
    end else if (flush) begin
      valid_d  = 1'b0;
      bubble_d = 1'b0;
    end else if (can_load) begin
      if (accept) begin
        valid_d   = 1'b1;
        bubble_d  = 1'b0;
        op_a_d    = fwd_a;
        op_b_d    = fwd_b;
        rd_d      = in_rd;
        wr_en_d   = in_wr_en;
        is_load_d = in_is_load;
      end else if (hazard) begin
        valid_d  = 1'b0;
        bubble_d = 1'b1;
        if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      end else begin
        valid_d  = 1'b0;
        bubble_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    bubble_q  <= bubble_d;
    op_a_q    <= op_a_d;
    op_b_q    <= op_b_d;
    rd_q      <= rd_d;
    wr_en_q   <= wr_en_d;
    is_load_q <= is_load_d;
    stall_q   <= stall_d;
  end

  assign out_valid   = valid_q;
  assign out_op_a    = op_a_q;
  assign out_op_b    = op_b_q;
  assign out_rd      = rd_q;
  assign out_wr_en   = wr_en_q;
  assign out_is_load = is_load_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed cases, random traffic against a
// behavioural model, and stall counter saturation.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [3:0]  in_rn, in_rm, in_rd, rf_sel_a, rf_sel_b, ex_rd, mem_rd, wb_rd, out_rd;
  logic        in_use_rn, in_use_rm, in_wr_en, in_is_load;
  logic [31:0] rf_data_a, rf_data_b, ex_result, mem_result, wb_data, out_op_a, out_op_b;
  logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic        out_valid, out_ready, out_wr_en, out_is_load;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  operand_fetch_stage #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_use_rn(in_use_rn), .in_use_rm(in_use_rm),
    .in_wr_en(in_wr_en), .in_is_load(in_is_load), .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        wr;
    logic        ld;
  } txn_t;

  txn_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_stall = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] resolve(input logic use_f, input logic [3:0] src,
                                          input logic [31:0] rf);
    if (!use_f) return 32'd0;
    if (ex_wr_en && ex_rd == src && !ex_is_load) return ex_result;
    if (mem_wr_en && mem_rd == src) return mem_result;
    if (wb_wr_en && wb_rd == src) return wb_data;
    return rf;
  endfunction

  // Called with inputs already driven just after a rising edge; returns just after the next one.
  task automatic cycle();
    logic        haz, can, rdy;
    logic        nv;
    logic [15:0] ns;
    txn_t        t;
    #1;
    haz = in_valid && ex_wr_en && ex_is_load &&
          ((in_use_rn && ex_rd == in_rn) || (in_use_rm && ex_rd == in_rm));
    can = !m_valid || out_ready;
    rdy = can && !haz && !flush;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("rf_sel_a", {28'd0, rf_sel_a}, {28'd0, in_rn});
    chk("rf_sel_b", {28'd0, rf_sel_b}, {28'd0, in_rm});
    if (reset) begin
      sb.delete();
      nv = 1'b0;
      ns = 16'd0;
    end else if (flush) begin
      sb.delete();
      nv = 1'b0;
      ns = m_stall;
    end else begin
      if (in_valid && rdy) begin
        t.a  = resolve(in_use_rn, in_rn, rf_data_a);
        t.b  = resolve(in_use_rm, in_rm, rf_data_b);
        t.rd = in_rd;
        t.wr = in_wr_en;
        t.ld = in_is_load;
        sb.push_back(t);
      end
      nv = can ? (in_valid && rdy) : m_valid;
      ns = (can && haz && m_stall != 16'hFFFF) ? m_stall + 16'd1 : m_stall;
    end
    @(posedge clk);
    #1;
    m_valid = nv;
    m_stall = ns;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
  endtask

  // Monitor: consume the held instruction on every completed handshake.
  always @(negedge clk) begin
    txn_t t;
    if (!reset && !flush && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got out_valid=1 expected no pending instruction at %0t", $time);
      end else begin
        t = sb.pop_front();
        chk("sb_op_a", out_op_a, t.a);
        chk("sb_op_b", out_op_b, t.b);
        chk("sb_rd", {28'd0, out_rd}, {28'd0, t.rd});
        chk("sb_wr_en", {31'd0, out_wr_en}, {31'd0, t.wr});
        chk("sb_is_load", {31'd0, out_is_load}, {31'd0, t.ld});
      end
    end
  end

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0;
    in_use_rn = 0; in_use_rm = 0; in_wr_en = 0; in_is_load = 0;
    rf_data_a = 0; rf_data_b = 0; ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_wr_en = 0; mem_rd = 0; mem_result = 0; wb_wr_en = 0; wb_rd = 0; wb_data = 0;
    out_ready = 1;
  endtask

  task automatic instr(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd);
    in_valid = 1; in_rn = rn; in_rm = rm; in_rd = rd;
    in_use_rn = 1; in_use_rm = 1; in_wr_en = 1; in_is_load = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_op_a"}, out_op_a, 32'd0);
    chk({tag, "_op_b"}, out_op_b, 32'd0);
    chk({tag, "_rd"}, {28'd0, out_rd}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, out_wr_en}, 32'd0);
    chk({tag, "_is_load"}, {31'd0, out_is_load}, 32'd0);
    chk({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    cycle();
    cycle();
    chk_all_zero("reset");
    reset = 0;
    #1 chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // No forwarding
    instr(4'd3, 4'd4, 4'd1); rf_data_a = 32'h11; rf_data_b = 32'h22;
    cycle();
    chk("plain_valid", {31'd0, out_valid}, 32'd1);
    chk("plain_op_a", out_op_a, 32'h11);
    chk("plain_op_b", out_op_b, 32'h22);

    // Forwarding priority EX > MEM > WB
    instr(4'd5, 4'd6, 4'd2);
    ex_wr_en = 1; mem_wr_en = 1; wb_wr_en = 1; ex_rd = 5; mem_rd = 5; wb_rd = 5;
    ex_result = 32'hA; mem_result = 32'hB; wb_data = 32'hC;
    cycle();
    chk("prio_ex", out_op_a, 32'hA);
    ex_wr_en = 0;
    cycle();
    chk("prio_mem", out_op_a, 32'hB);
    mem_wr_en = 0;
    cycle();
    chk("prio_wb", out_op_a, 32'hC);
    wb_wr_en = 0;

    // Load-use bubble, then MEM forwarding of the load result
    instr(4'd2, 4'd9, 4'd3);
    ex_wr_en = 1; ex_is_load = 1; ex_rd = 2;
    #1 chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_stall", {16'd0, stall_cnt}, 32'd1);
    ex_wr_en = 0; ex_is_load = 0; mem_wr_en = 1; mem_rd = 2; mem_result = 32'h55;
    cycle();
    chk("lu_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_op_a", out_op_a, 32'h55);
    mem_wr_en = 0;

    // Unused source never hazards and reads as zero
    instr(4'd1, 4'd7, 4'd4); in_use_rm = 0; rf_data_a = 32'h99; rf_data_b = 32'h77;
    ex_wr_en = 1; ex_is_load = 1; ex_rd = 7;
    cycle();
    chk("unused_valid", {31'd0, out_valid}, 32'd1);
    chk("unused_op_b", out_op_b, 32'd0);
    ex_wr_en = 0; ex_is_load = 0;

    // Backpressure holds outputs for three cycles
    out_ready = 0;
    instr(4'd8, 4'd9, 4'd5); rf_data_a = 32'h123; rf_data_b = 32'h456;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_op_a", out_op_a, 32'h99);
      chk("bp_op_b", out_op_b, 32'd0);
      chk("bp_rd", {28'd0, out_rd}, 32'd4);
    end
    out_ready = 1;
    cycle();
    chk("bp_release_op_a", out_op_a, 32'h123);
    chk("bp_release_rd", {28'd0, out_rd}, 32'd5);

    // Flush wins over a hazard
    instr(4'd6, 4'd0, 4'd6); ex_wr_en = 1; ex_is_load = 1; ex_rd = 6; flush = 1;
    cycle();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_stall", {16'd0, stall_cnt}, 32'd1);
    flush = 0; ex_wr_en = 0; ex_is_load = 0;
    cycle();
    out_ready = 0;
    reset = 1;
    cycle();
    chk_all_zero("mid_reset");
    reset = 0; out_ready = 1; in_valid = 0;
    cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 9) < 8);
      in_rn      = 4'($urandom_range(0, 3));
      in_rm      = 4'($urandom_range(0, 3));
      in_rd      = 4'($urandom);
      in_use_rn  = 1'($urandom);
      in_use_rm  = 1'($urandom);
      in_wr_en   = 1'($urandom);
      in_is_load = 1'($urandom);
      rf_data_a  = $urandom;
      rf_data_b  = $urandom;
      ex_wr_en   = 1'($urandom);
      ex_is_load = ($urandom_range(0, 9) < 3);
      ex_rd      = 4'($urandom_range(0, 3));
      ex_result  = $urandom;
      mem_wr_en  = 1'($urandom);
      mem_rd     = 4'($urandom_range(0, 3));
      mem_result = $urandom;
      wb_wr_en   = 1'($urandom);
      wb_rd      = 4'($urandom_range(0, 3));
      wb_data    = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Saturation of the bubble counter under a persistent hazard
    idle();
    reset = 1;
    cycle();
    reset = 0;
    instr(4'd3, 4'd3, 4'd3); ex_wr_en = 1; ex_is_load = 1; ex_rd = 3;
    for (int n = 0; n < 65537; n++) cycle();
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    cycle();
    chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
